// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver with mid-bit sampling, framing/glitch/overrun detection,
// a valid/ack holding register and saturating match/mismatch byte counters.
module uart_rx_monitor #(
   parameter int          CLKS_PER_BIT  = 10408,
   parameter logic [7:0]  EXPECTED_BYTE = 8'h55
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   output logic [7:0]  data_out,
   output logic        data_valid,
   input  logic        data_ack,
   output logic        frame_err,
   output logic        overrun,
   output logic [15:0] match_cnt,
   output logic [15:0] mismatch_cnt
);

   localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] FULL_LOAD = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   logic        rx_meta_q;
   logic        rx_s_q;
   state_t      state_q,        state_d;
   logic [15:0] baud_cnt_q,     baud_cnt_d;
   logic [2:0]  bit_idx_q,      bit_idx_d;
   logic [7:0]  shift_q,        shift_d;
   logic [7:0]  data_out_q,     data_out_d;
   logic        data_valid_q,   data_valid_d;
   logic        frame_err_q,    frame_err_d;
   logic        overrun_q,      overrun_d;
   logic [15:0] match_cnt_q,    match_cnt_d;
   logic [15:0] mismatch_cnt_q, mismatch_cnt_d;

   // Two-flop synchronizer; resets to the idle (high) line level.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         baud_cnt_q     <= '0;
         bit_idx_q      <= '0;
         shift_q        <= '0;
         data_out_q     <= '0;
         data_valid_q   <= 1'b0;
         frame_err_q    <= 1'b0;
         overrun_q      <= 1'b0;
         match_cnt_q    <= '0;
         mismatch_cnt_q <= '0;
      end else begin
         state_q        <= state_d;
         baud_cnt_q     <= baud_cnt_d;
         bit_idx_q      <= bit_idx_d;
         shift_q        <= shift_d;
         data_out_q     <= data_out_d;
         data_valid_q   <= data_valid_d;
         frame_err_q    <= frame_err_d;
         overrun_q      <= overrun_d;
         match_cnt_q    <= match_cnt_d;
         mismatch_cnt_q <= mismatch_cnt_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      baud_cnt_d     = baud_cnt_q;
      bit_idx_d      = bit_idx_q;
      shift_d        = shift_q;
      data_out_d     = data_out_q;
      data_valid_d   = data_valid_q;
      frame_err_d    = 1'b0;
      overrun_d      = 1'b0;
      match_cnt_d    = match_cnt_q;
      mismatch_cnt_d = mismatch_cnt_q;

      // Ack is applied first so a completing byte below overrides it.
      if (data_ack && data_valid_q) begin
         data_valid_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (!rx_s_q) begin
               state_d    = S_START;
               baud_cnt_d = HALF_LOAD;
            end
         end
         S_START: begin
            if (baud_cnt_q == 16'd0) begin
               if (rx_s_q) begin
                  state_d = S_IDLE;
               end else begin
                  state_d    = S_DATA;
                  baud_cnt_d = FULL_LOAD;
                  bit_idx_d  = 3'd0;
               end
            end else begin
               baud_cnt_d = baud_cnt_q - 16'd1;
            end
         end
         S_DATA: begin
            if (baud_cnt_q == 16'd0) begin
               shift_d[bit_idx_q] = rx_s_q;
               baud_cnt_d         = FULL_LOAD;
               bit_idx_d          = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end
            end else begin
               baud_cnt_d = baud_cnt_q - 16'd1;
            end
         end
         S_STOP: begin
            if (baud_cnt_q == 16'd0) begin
               if (rx_s_q) begin
                  data_out_d   = shift_q;
                  data_valid_d = 1'b1;
                  overrun_d    = data_valid_q && !data_ack;
                  if (shift_q == EXPECTED_BYTE) begin
                     if (match_cnt_q != 16'hFFFF) match_cnt_d = match_cnt_q + 16'd1;
                  end else begin
                     if (mismatch_cnt_q != 16'hFFFF) mismatch_cnt_d = mismatch_cnt_q + 16'd1;
                  end
                  state_d = S_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = S_BREAK;
               end
            end else begin
               baud_cnt_d = baud_cnt_q - 16'd1;
            end
         end
         S_BREAK: begin
            // Hold here so a stuck-low line reports a single framing error.
            if (rx_s_q) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign data_out     = data_out_q;
   assign data_valid   = data_valid_q;
   assign frame_err    = frame_err_q;
   assign overrun      = overrun_q;
   assign match_cnt    = match_cnt_q;
   assign mismatch_cnt = mismatch_cnt_q;

endmodule

// File: doc/uart_rx_monitor.md
Name: uart_rx_monitor

Overview:
- Serial receiver for the board-level UART line driven by the team's test-pattern transmitter (8N1, LSB first, idle high).
- Recovers bytes with mid-bit sampling and flags framing errors, glitches and overruns.
- Presents each byte on a valid/ack holding register for a downstream checker or LED/debug logic.
- Sits directly downstream of the transmitter's serial output, on the same clock domain or an asynchronous one.

Parameters:
- CLKS_PER_BIT, 10408, clk cycles per bit (9600 baud at ~100 MHz). Legal range 4..65535; 16-bit counter.
- EXPECTED_BYTE, 8'h55, reference value for the match/mismatch counters.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- rx  input  1  serial line, asynchronous, idle high
- data_out  output  8  last received byte
- data_valid  output  1  data_out holds an unacknowledged byte
- data_ack  input  1  consumer accepts data_out; clears data_valid
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: new byte completed while data_valid=1 and no ack
- match_cnt  output  16  count of bytes equal to EXPECTED_BYTE, saturating
- mismatch_cnt  output  16  count of bytes not equal to EXPECTED_BYTE, saturating

Behaviour:
Synchronizer and reset
- rx passes through a 2-flop synchronizer; both flops reset to 1. All logic below uses the synchronized rx_s.
- Reset values: data_out=0, data_valid=0, frame_err=0, overrun=0, match_cnt=0, mismatch_cnt=0, state=IDLE, bit counter=0, baud counter=0.
- rst mid-frame aborts reception; no partial byte and no error flag is reported.

State machine: IDLE, START, DATA, STOP, BREAK
- IDLE: when rx_s==0, go to START and load the baud counter with CLKS_PER_BIT/2 - 1 (integer division).
- START: decrement the counter. When it reaches 0, sample rx_s:
  - rx_s==1: glitch; return to IDLE with no flags.
  - rx_s==0: go to DATA, load the counter with CLKS_PER_BIT-1, clear the bit index.
- DATA: when the counter reaches 0, sample rx_s into shift[bit index], LSB first, and reload CLKS_PER_BIT-1. After the 8th sample (index 7), go to STOP.
- STOP: when the counter reaches 0, sample rx_s:
  - rx_s==1: byte accepted. On the next edge:
    - data_out <= shift; data_valid <= 1.
    - Increment match_cnt or mismatch_cnt; both saturate at 16'hFFFF.
    - If data_valid was already 1 and data_ack is low this cycle, pulse overrun. The new byte still overwrites data_out.
    - Return to IDLE.
  - rx_s==0: pulse frame_err; data_out, data_valid and the counters are unchanged; go to BREAK.
- BREAK: wait until rx_s==1, then go to IDLE. A held-low line produces exactly one frame_err.

Timing and handshake
- Sampling points are at bit centre ±1 cycle. Back-to-back frames with a single stop bit must be received: IDLE is re-entered within half a bit of the stop-bit centre.
- data_ack while data_valid=1 clears data_valid on the next edge. data_ack while data_valid=0 is ignored.
- Byte completion and data_ack in the same cycle: completion wins; data_valid stays 1, data_out takes the new byte, no overrun.
- data_valid assertion latency is CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 3 cycles (±1) after the rx falling edge at the pin.

Test Plan:
1. CLKS_PER_BIT=16; drive idle-idle-start-0x55-stop repeatedly with ack after each byte -> data_out=0x55 per frame, match_cnt increments, mismatch_cnt=0, no error pulses.
2. Send 0xA3 then 0x00 back-to-back with one stop bit each -> two data_valid events with values 0xA3 then 0x00, mismatch_cnt=2.
3. Low pulse on rx of 5 cycles (shorter than half bit) -> no state change beyond START, no data_valid, no flags.
4. Frame 0x41 with stop bit forced low, then line held low 100 cycles -> exactly one frame_err pulse, data_valid remains 0, counters unchanged; next good frame 0x42 is received correctly.
5. Two bytes 0x11, 0x22 with no ack -> overrun pulses once at the second completion, data_out=0x22, data_valid=1. Then assert data_ack on the exact completion cycle of a third byte 0x33 -> data_valid stays 1, data_out=0x33, no overrun.
6. Assert rst during DATA bit 4 of a frame -> all outputs return to reset values next cycle; the remainder of the aborted frame yields at most a resync (glitch or frame_err) but never a false data_valid with a corrupted byte counted as a match.
